reset_seq: RTL
==============

Name: reset_seq

Overview:
- Reset sequencer that generates the staggered, active-low synchronous resets consumed by downstream sync_rst-style flops.
- Synchronizes an external reset request and enforces a minimum assertion width.
- Releases NUM_OUT reset domains one at a time in index order, then flags completion.
- Sits between board/system reset sources and the per-block synchronous reset inputs.

Parameters:
- NUM_OUT, 4, number of reset domains; must be >= 1.
- HOLD_CYCLES, 16, minimum cycles all outputs stay asserted after the request clears; must be >= 1.
- STAGGER, 8, cycles between successive domain releases; must be >= 1.
- SYNC_STAGES, 2, flop stages on rst_req_in; must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- rst_req_in  input  1  asynchronous reset request, active-high
- rst_n_out  output  NUM_OUT  per-domain reset, active-low, registered
- done  output  1  high when every rst_n_out bit is released

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. No asynchronous reset exists anywhere in the block.
- Under rst:
  - rst_n_out = all 0, done = 0.
  - State = HOLD, hold counter = 0, stagger counter = 0, domain index = 0.
  - Synchronizer flops are cleared to 0.
- req_s is rst_req_in after SYNC_STAGES flops.
- A request pulse must be >= 1 clk period high to be guaranteed captured.
- State HOLD:
  - All outputs are asserted.
  - Each edge with req_s=0 increments the hold counter. Any edge with req_s=1 clears it.
  - On the edge where the counter = HOLD_CYCLES-1 and req_s=0: rst_n_out[0] goes to 1, and the state moves to RELEASE (index=1, stagger counter=0).
  - With no request, rst_n_out[0] rises HOLD_CYCLES edges after the first edge with rst=0.
- State RELEASE:
  - The stagger counter increments each edge.
  - When it reaches STAGGER-1: rst_n_out[index] goes to 1, the counter clears, and index increments.
  - rst_n_out[k] rises k*STAGGER edges after rst_n_out[0].
  - On the edge releasing bit NUM_OUT-1: done goes to 1 and the state moves to RUN.
  - If NUM_OUT=1, HOLD goes directly to RUN and done rises with rst_n_out[0].
- State RUN:
  - Outputs stay all 1 and done stays 1.
- Request in any state:
  - The edge after req_s=1 drives rst_n_out = all 0 and done = 0.
  - The state moves to HOLD with all counters cleared.
  - Latency from rst_req_in rising (setup met) to outputs low: SYNC_STAGES+1 edges.
- Release ordering: rst_n_out bits only ever release in ascending index order. The value is always a thermometer code: low bits released first.
- rst mid-sequence takes priority over everything: outputs are all 0 on the next edge and the sequence restarts.
- Counter widths are sized with $clog2 of the matching parameter, with a minimum of 1 bit. No wrap occurs in normal operation, because counters clear on their terminal value.

Optional Feature:
- Macro RESET_SEQ_WDOG_EN.
- When defined:
  - Adds parameter WDOG_CYCLES (default 64).
  - Adds input wdog_kick (1 bit) and output wdog_fired (1 bit).
  - In RUN, the watchdog counter increments each edge and clears on wdog_kick=1.
  - When it reaches WDOG_CYCLES-1 without a kick: wdog_fired pulses high for exactly 1 cycle and the block behaves as a request (outputs all 0 next edge, state HOLD).
  - The counter is held at 0 outside RUN and under rst.
  - wdog_fired resets to 0.
- When undefined: the ports, parameter and counter do not exist, and behaviour is as above.

Decomposition:
- Package reset_seq_pkg holds:
  - typedef enum state_t {HOLD, RELEASE, RUN}
  - function cnt_w(n) returning max(1, $clog2(n))
- One sub-module, sync_bit (parameter STAGES, synchronous active-high reset to 0), provides the request synchronizer and is reusable elsewhere.

Test Plan (defaults NUM_OUT=4, HOLD_CYCLES=16, STAGGER=8, SYNC_STAGES=2):
- Power-on:
  - Stimulus: rst=1 for 3 cycles, then 0, req held low.
  - Required response: rst_n_out=0000 until edge 16, then 0001 at edge 16, 0011 at edge 24, 0111 at edge 32, 1111 with done=1 at edge 40.
- Request in RUN:
  - Stimulus: rst_req_in high for 1 cycle.
  - Required response: rst_n_out=0000 and done=0 three edges after the rise. After req_s falls, the full 16/8/8/8 release sequence repeats.
- Long request:
  - Stimulus: rst_req_in high for 30 cycles.
  - Required response: outputs stay 0000 throughout. rst_n_out[0] rises 16 edges after req_s falls.
- Request mid-release:
  - Stimulus: assert the request while rst_n_out=0011.
  - Required response: 0000 within 3 edges. No bit ever shows a non-thermometer pattern. A full HOLD period elapses before 0001.
- rst mid-release:
  - Stimulus: rst=1 for 1 cycle while rst_n_out=0111.
  - Required response: 0000 and done=0 on the next edge; the sequence restarts from a hold count of 0.
- Watchdog, with RESET_SEQ_WDOG_EN and WDOG_CYCLES=64:
  - No kick in RUN: wdog_fired is a 1-cycle pulse 64 edges after entering RUN, outputs are 0000 on the next edge, and the sequence reruns.
  - Kick every 50 cycles: wdog_fired never asserts across 500 cycles.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Counter width for a count range of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high clear.
// Latency: STAGES clk edges from din to dout.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (sync, active-high, clears chain to 0), din (async), dout.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: holds all domains in reset, then releases them one by one in index order.
// Latency: request to all-asserted is SYNC_STAGES+1 edges; release spacing HOLD_CYCLES then STAGGER.
// Backpressure: none; a request or rst restarts the sequence from any state.
// Ports: clk, rst (sync active-high), rst_req_in (async request), rst_n_out[NUM_OUT] (active-low,
//        thermometer-coded, registered), done (all domains released).
// Optional RESET_SEQ_WDOG_EN: adds WDOG_CYCLES, wdog_kick, wdog_fired; a missed kick in RUN acts as a request.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8,
    parameter int SYNC_STAGES = 2
`ifdef RESET_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_req_in,
`ifdef RESET_SEQ_WDOG_EN
    input  logic               wdog_kick,
    output logic               wdog_fired,
`endif
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               done
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int SW = cnt_w(STAGGER);
    localparam int IW = cnt_w(NUM_OUT);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    logic req_s;
    logic req_any;

    state_t             state_q,     state_d;
    logic [HW-1:0]      hold_cnt_q,  hold_cnt_d;
    logic [SW-1:0]      stg_cnt_q,   stg_cnt_d;
    logic [IW-1:0]      idx_q,       idx_d;
    logic [NUM_OUT-1:0] rst_n_out_q, rst_n_out_d;
    logic               done_q,      done_d;

`ifdef RESET_SEQ_WDOG_EN
    localparam int WW = cnt_w(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_fired_q, wdog_fired_d;
`endif

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_req_in),
        .dout (req_s)
    );

    // A watchdog expiry is turned into a request one edge after the fired pulse.
`ifdef RESET_SEQ_WDOG_EN
    assign req_any = req_s | wdog_fired_q;
`else
    assign req_any = req_s;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        idx_d       = idx_q;
        rst_n_out_d = rst_n_out_q;
        done_d      = done_q;
`ifdef RESET_SEQ_WDOG_EN
        wdog_cnt_d   = '0;
        wdog_fired_d = 1'b0;
`endif

        if (req_any) begin
            state_d     = HOLD;
            hold_cnt_d  = '0;
            stg_cnt_d   = '0;
            idx_d       = '0;
            rst_n_out_d = '0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    rst_n_out_d = '0;
                    done_d      = 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d  = '0;
                        stg_cnt_d   = '0;
                        rst_n_out_d = NUM_OUT'(1);
                        if (NUM_OUT == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                RELEASE: begin
                    if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d   = '0;
                        // OR-in the next bit so the output stays a thermometer code.
                        rst_n_out_d = rst_n_out_q | (NUM_OUT'(1) << idx_q);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + SW'(1);
                    end
                end
                RUN: begin
                    rst_n_out_d = '1;
                    done_d      = 1'b1;
`ifdef RESET_SEQ_WDOG_EN
                    if (wdog_kick) begin
                        wdog_cnt_d = '0;
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        wdog_cnt_d   = '0;
                        wdog_fired_d = 1'b1;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + WW'(1);
                    end
`endif
                end
                default: begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    stg_cnt_d   = '0;
                    idx_d       = '0;
                    rst_n_out_d = '0;
                    done_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            stg_cnt_q   <= '0;
            idx_q       <= '0;
            rst_n_out_q <= '0;
            done_q      <= 1'b0;
`ifdef RESET_SEQ_WDOG_EN
            wdog_cnt_q   <= '0;
            wdog_fired_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            idx_q       <= idx_d;
            rst_n_out_q <= rst_n_out_d;
            done_q      <= done_d;
`ifdef RESET_SEQ_WDOG_EN
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fired_q <= wdog_fired_d;
`endif
        end
    end

    assign rst_n_out = rst_n_out_q;
    assign done      = done_q;
`ifdef RESET_SEQ_WDOG_EN
    assign wdog_fired = wdog_fired_q;
`endif

endmodule
